// File: rtl/serial_shifter.sv
// 16-bit MSB-first serial transmitter driven by an external frame controller.
// One-entry holding buffer, frame-alignment checking, sticky error flags and a completed-frame counter.
module serial_shifter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_25k,
  input  logic             rst_n,
  input  logic             start,
  input  logic             str,
  input  logic [15:0]      din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             err_clr,
  output logic             sdata,
  output logic             shift_en,
  output logic             latch,
  output logic             underrun,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [15:0] hold_word;
  logic        buf_full;
  logic [15:0] shreg;
  logic [15:0] last_word;
  logic [3:0]  bit_cnt;
  logic        active;

  logic accept;
  logic last_bit;
  logic bad_start;
  logic bad_str;

  assign accept    = din_valid & ~buf_full;
  assign last_bit  = active && (bit_cnt == 4'd15);
  assign bad_start = start && active && (bit_cnt != 4'd15);
  assign bad_str   = str && !(active && (bit_cnt == 4'd14));

  assign din_ready = ~buf_full;
  assign sdata     = active ? shreg[15] : 1'b0;
  assign shift_en  = active;

  // Buffer payload is qualified by buf_full, so it needs no reset.
  always_ff @(posedge clk_25k) begin
    if (accept) hold_word <= din;
  end

  always_ff @(posedge clk_25k or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      last_word <= '0;
      buf_full  <= 1'b0;
      bit_cnt   <= '0;
      active    <= 1'b0;
      latch     <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      latch <= 1'b0;

      if (err_clr) begin
        underrun  <= 1'b0;
        frame_err <= 1'b0;
      end
      if (bad_start || bad_str) frame_err <= 1'b1;

      if (accept) buf_full <= 1'b1;

      // A word accepted on the load edge lands in the buffer for the next frame, never this one.
      if (start) begin
        if (buf_full) begin
          shreg     <= hold_word;
          last_word <= hold_word;
          buf_full  <= 1'b0;
        end else begin
          shreg    <= last_word;
          underrun <= 1'b1;
        end
        bit_cnt <= '0;
        active  <= 1'b1;
      end else if (active) begin
        if (bit_cnt == 4'd15) begin
          active <= 1'b0;
        end else begin
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + 4'd1;
        end
      end

      // Only a frame that reaches its final bit counts; aborted frames never get here.
      if (last_bit) begin
        latch     <= 1'b1;
        frame_cnt <= frame_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_serial_shifter.sv
// Directed, scoreboard-based bench for serial_shifter: expected serial bits are queued
// at each frame load and popped as the DUT shifts them out.
`timescale 1us/1ns
module tb_serial_shifter;

  logic        clk_25k = 1'b0;
  logic        rst_n;
  logic        start;
  logic        str;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        err_clr;
  logic        sdata;
  logic        shift_en;
  logic        latch;
  logic        underrun;
  logic        frame_err;
  logic [7:0]  frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic        exp_q[$];
  logic [15:0] mdl_buf[$];
  logic [15:0] mdl_last;
  logic        mdl_underrun;
  logic [7:0]  mdl_cnt;

  serial_shifter #(.CNT_W(8)) dut (
    .clk_25k   (clk_25k),
    .rst_n     (rst_n),
    .start     (start),
    .str       (str),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .err_clr   (err_clr),
    .sdata     (sdata),
    .shift_en  (shift_en),
    .latch     (latch),
    .underrun  (underrun),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk_25k = ~clk_25k;

  task automatic tick();
    @(posedge clk_25k);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mdl_buf.delete();
    mdl_last     = 16'h0000;
    mdl_underrun = 1'b0;
    mdl_cnt      = 8'd0;
  endtask

  task automatic model_load();
    logic [15:0] w;
    if (mdl_buf.size() > 0) begin
      w        = mdl_buf.pop_front();
      mdl_last = w;
    end else begin
      w            = mdl_last;
      mdl_underrun = 1'b1;
    end
    for (int i = 15; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  task automatic pop_check_sdata(input string tag);
    logic e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, {31'd0, sdata}, {31'd0, e});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_word(input logic [15:0] w);
    check("din_ready_before_push", {31'd0, din_ready}, 32'd1);
    din       = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    mdl_buf.push_back(w);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr      = 1'b0;
    mdl_underrun = 1'b0;
  endtask

  // n back-to-back well-formed frames; optionally offers next_w right after the first load.
  task automatic run_frames(input int n, input bit has_next, input logic [15:0] next_w);
    for (int f = 0; f < n; f++) begin
      model_load();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 16; k++) begin
        check("latch_in_frame", {31'd0, latch}, {31'd0, (k == 0 && f > 0)});
        pop_check_sdata("sdata_bit");
        check("shift_en_in_frame", {31'd0, shift_en}, 32'd1);
        if (f == 0 && k == 0 && has_next) begin
          din       = next_w;
          din_valid = 1'b1;
          mdl_buf.push_back(next_w);
        end
        if (k == 14) str = 1'b1;
        if (k < 15) begin
          tick();
          str       = 1'b0;
          din_valid = 1'b0;
        end
      end
      mdl_cnt = mdl_cnt + 8'd1;
    end
    tick();
    check("latch_after_frame", {31'd0, latch}, 32'd1);
    check("shift_en_idle", {31'd0, shift_en}, 32'd0);
    check("sdata_idle", {31'd0, sdata}, 32'd0);
    check("frame_cnt", {24'd0, frame_cnt}, {24'd0, mdl_cnt});
    tick();
    check("latch_one_cycle", {31'd0, latch}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    str       = 1'b0;
    din       = 16'h0000;
    din_valid = 1'b0;
    err_clr   = 1'b0;
    model_reset();
    #1;
    check("rst_sdata", {31'd0, sdata}, 32'd0);
    check("rst_shift_en", {31'd0, shift_en}, 32'd0);
    check("rst_din_ready", {31'd0, din_ready}, 32'd1);
    check("rst_latch", {31'd0, latch}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single frame of A5C3
    push_word(16'hA5C3);
    check("din_ready_full", {31'd0, din_ready}, 32'd0);
    run_frames(1, 1'b0, 16'h0000);
    check("a5c3_frame_cnt", {24'd0, frame_cnt}, 32'd1);
    check("a5c3_underrun", {31'd0, underrun}, 32'd0);
    check("a5c3_frame_err", {31'd0, frame_err}, 32'd0);
    check("a5c3_din_ready", {31'd0, din_ready}, 32'd1);

    // Underrun with no word pushed since reset
    do_reset();
    run_frames(1, 1'b0, 16'h0000);
    check("underrun_set", {31'd0, underrun}, {31'd0, mdl_underrun});
    check("underrun_set_const", {31'd0, underrun}, 32'd1);
    clear_errors();
    check("underrun_cleared", {31'd0, underrun}, 32'd0);

    // Back-to-back FFFF then 0001
    do_reset();
    push_word(16'hFFFF);
    run_frames(2, 1'b1, 16'h0001);
    check("b2b_frame_cnt", {24'd0, frame_cnt}, 32'd2);
    check("b2b_underrun", {31'd0, underrun}, 32'd0);
    check("b2b_frame_err", {31'd0, frame_err}, 32'd0);

    // Misplaced strobe at bit_cnt 10
    do_reset();
    push_word(16'h1357);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("str10_no_err_yet", {31'd0, frame_err}, 32'd0);
    str = 1'b1;
    tick();
    str = 1'b0;
    check("str10_frame_err", {31'd0, frame_err}, 32'd1);
    check("str10_still_active", {31'd0, shift_en}, 32'd1);
    repeat (5) tick();
    check("str10_latch", {31'd0, latch}, 32'd1);
    tick();
    clear_errors();
    check("str10_err_cleared", {31'd0, frame_err}, 32'd0);

    // Misaligned start at bit_cnt 5 aborts and reloads
    do_reset();
    push_word(16'h0F0F);
    model_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.delete();
    push_word(16'hC35A);
    repeat (4) tick();
    check("abort_latch_before", {31'd0, latch}, 32'd0);
    model_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_frame_err", {31'd0, frame_err}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      check("abort_no_latch", {31'd0, latch}, 32'd0);
      pop_check_sdata("abort_reload_sdata");
      if (k < 15) tick();
    end
    tick();
    check("abort_new_frame_latch", {31'd0, latch}, 32'd1);
    check("abort_frame_cnt", {24'd0, frame_cnt}, 32'd1);
    check("abort_underrun", {31'd0, underrun}, 32'd0);

    // Asynchronous reset mid-frame at bit_cnt 8
    do_reset();
    push_word(16'hFFFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("pre_rst_shift_en", {31'd0, shift_en}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_sdata", {31'd0, sdata}, 32'd0);
    check("async_rst_shift_en", {31'd0, shift_en}, 32'd0);
    check("async_rst_din_ready", {31'd0, din_ready}, 32'd1);
    check("async_rst_latch", {31'd0, latch}, 32'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    repeat (10) begin
      tick();
      check("post_rst_no_latch", {31'd0, latch}, 32'd0);
    end
    check("post_rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    push_word(16'h3C3C);
    run_frames(1, 1'b0, 16'h0000);
    check("post_rst_underrun", {31'd0, underrun}, 32'd0);

    // 256 frames wrap the counter; set beats clear
    do_reset();
    run_frames(256, 1'b0, 16'h0000);
    check("wrap_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    check("wrap_underrun", {31'd0, underrun}, 32'd1);
    check("wrap_no_frame_err", {31'd0, frame_err}, 32'd0);
    str     = 1'b1;
    err_clr = 1'b1;
    tick();
    str     = 1'b0;
    err_clr = 1'b0;
    check("set_wins_frame_err", {31'd0, frame_err}, 32'd1);
    check("clr_underrun", {31'd0, underrun}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_shifter.md
SERIAL_SHIFTER -- requirements
Module: serial_shifter

Interface
REQ-001 Parameter: CNT_W, default 8, width of frame counter.
REQ-002 clk_25k  in  1  sole clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  frame-start pulse from frame controller, one cycle every 16 cycles.
REQ-005 str  in  1  strobe pulse from frame controller, one cycle, immediately precedes start.
REQ-006 din  in  16  parallel word to transmit.
REQ-007 din_valid  in  1  din holds a word.
REQ-008 din_ready  out  1  holding buffer empty; word accepted on din_valid & din_ready.
REQ-009 err_clr  in  1  clears sticky error flags.
REQ-010 sdata  out  1  serial data, MSB first.
REQ-011 shift_en  out  1  high while a frame bit is on sdata.
REQ-012 latch  out  1  one-cycle pulse after 16th bit.
REQ-013 underrun  out  1  sticky: frame loaded with no new word.
REQ-014 frame_err  out  1  sticky: start/str out of frame alignment.
REQ-015 frame_cnt  out  CNT_W  completed-frame count.

Function
REQ-016 The block SHALL hold a one-entry buffer (buf, buf_full); din_ready SHALL equal ~buf_full; accept sets buf_full and stores din.
REQ-017 Edge A, start sampled high: shreg <= buf if buf_full (buf_full <= 0, last_word <= buf), else shreg <= last_word and underrun <= 1; bit_cnt <= 0; active <= 1.
REQ-018 At load edge with buf empty and din_valid high, the word SHALL be accepted into buf but NOT used for that frame (no bypass).
REQ-019 sdata SHALL equal shreg[15] when active, else 0; shift_en SHALL equal active.
REQ-020 Each edge with active, bit_cnt < 15, no start: shreg <= shreg << 1, bit_cnt <= bit_cnt + 1; bit k of frame appears after edge A+(15-k)... i.e. bit 15 after A, bit 0 after A+15.
REQ-021 Edge with active and bit_cnt == 15: latch <= 1 for one cycle, frame_cnt <= frame_cnt + 1 (wraps 2^CNT_W-1 -> 0); active <= start ? 1 (reload per REQ-017) : 0.
REQ-022 Back-to-back frames (start at A+16) SHALL produce continuous sdata with no idle cycle.
REQ-023 str sampled high SHALL be legal only when active and bit_cnt == 14; otherwise frame_err <= 1.
REQ-024 start sampled high while active and bit_cnt != 15 SHALL set frame_err, abort current frame without latch, and reload per REQ-017.
REQ-025 err_clr SHALL clear underrun and frame_err; simultaneous set and clear: set wins.
REQ-026 latch SHALL not assert for any aborted frame.

Reset
REQ-027 rst_n low SHALL immediately force: shreg 0, last_word 0, buf_full 0, bit_cnt 0, active 0, latch 0, underrun 0, frame_err 0, frame_cnt 0; hence sdata 0, shift_en 0, din_ready 1.
REQ-028 Reset mid-frame SHALL abort the frame with no latch; first start after release behaves as REQ-017.

Verification
REQ-029 Push din=16'hA5C3, start at A, str at A+15: sdata after A..A+15 = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; latch high A+16 only; frame_cnt=1; no errors.
REQ-030 No word pushed, start pulse: sdata all 0 (last_word=0), underrun=1, latch still pulses; err_clr -> underrun=0.
REQ-031 Words 16'hFFFF then 16'h0001 pushed, starts at A and A+16: 16 ones then 15 zeros and 1, shift_en continuous 32 cycles, two latch pulses, frame_cnt=2.
REQ-032 str at bit_cnt==10, and separately start at bit_cnt==5: frame_err=1; second case no latch, new frame loads.
REQ-033 rst_n low at bit_cnt==8 asynchronously: outputs zero before next edge, no latch, din_ready=1.
REQ-034 CNT_W=8, 256 frames: frame_cnt wraps to 0; err_clr coincident with a frame_err event leaves frame_err=1.
